// File: rtl/ifetch_prefetch_queue.sv
// Sequential instruction prefetcher: issues word fetches, queues {pc, insn}, and hands them to the core.
// Latency: request combinational from state; response visible on inst_* one cycle after it arrives.
// Backpressure: a request is only issued when queue space is reserved for it, so a full queue stalls fetch.
module ifetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic [31:0]                mem_req_addr,
  input  logic                       mem_rsp_valid,
  input  logic [31:0]                mem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst_pc,
  output logic [31:0]                inst_data,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       rsp_err
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  // Fetch/response address tracking and in-flight accounting.
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          rsp_err_q, rsp_err_d;

  // Instruction queue: circular buffer with explicit occupancy count.
  logic [LW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  // Per-cycle events.
  logic          req_fire;
  logic          rsp_ok;
  logic          rsp_unexp;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] live;
  logic [31:0]   reserved;
  logic [31:0]   redirect_tgt;

  // Issue only when an entry is guaranteed to be free for the response
  // (queued entries plus live requests stay below DEPTH); a redirect
  // withdraws any pending request for this cycle.
  always_comb begin
    live          = inflight_q - discard_q;
    reserved      = 32'(count_q) + 32'(live);
    mem_req_valid = !rst && !redirect_valid
                    && (32'(inflight_q) < 32'(MAX_OUT))
                    && (reserved < 32'(DEPTH));
    mem_req_addr  = fetch_pc_q;
  end

  // Head of the queue is read straight out of storage; nothing bypasses it.
  always_comb begin
    inst_valid = (count_q != '0);
    inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;
    inst_data  = inst_valid ? data_mem_q[rd_ptr_q] : 32'h0;
    fill_level = count_q;
    rsp_err    = rsp_err_q;
  end

  // Next-state: redirect has priority over pop/push and turns every
  // remaining in-flight request into one to be discarded.
  always_comb begin
    req_fire     = mem_req_valid && mem_req_ready;
    rsp_ok       = mem_rsp_valid && (inflight_q != '0);
    rsp_unexp    = mem_rsp_valid && (inflight_q == '0);
    rsp_drop     = rsp_ok && ((discard_q != '0) || redirect_valid);
    push         = rsp_ok && !rsp_drop;
    pop          = inst_valid && inst_ready && !redirect_valid;
    redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    fetch_pc_d   = fetch_pc_q;
    rsp_pc_d     = rsp_pc_q;
    inflight_d   = inflight_q + CW'(req_fire) - CW'(rsp_ok);
    discard_d    = discard_q;
    rsp_err_d    = rsp_err_q | rsp_unexp;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      discard_d  = inflight_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + LW'(push) - LW'(pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      rsp_err_q  <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rsp_err_q  <= rsp_err_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage write; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
      data_mem_q[wr_ptr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifetch_prefetch_queue.sv
// Bench for ifetch_prefetch_queue: in-order memory model plus an epoch-tagged queue reference model.
// Every cycle the DUT outputs are compared with the model; scenario tasks add directed checks.
// Memory latency, ready signals and redirects are randomized in the final scenario.
module tb_ifetch_prefetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          MAX_OUT  = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int          LW       = $clog2(DEPTH + 1);
  localparam logic [31:0] KEY      = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_req_addr;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_pc;
  logic [31:0]   inst_data;
  logic [LW-1:0] fill_level;
  logic          rsp_err;

  ifetch_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
    .fill_level(fill_level), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int ep; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] dat; } ent_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          ep = 0;
  logic        inject = 1'b0;
  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] m_fetch;
  logic [31:0] m_rsp;
  logic        m_err;
  logic [31:0] req_log[$];
  logic [31:0] obs_log[$];
  int          n_pop = 0;

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_fetch = RESET_PC;
    m_rsp   = RESET_PC;
    m_err   = 1'b0;
    ep++;
  endtask

  // One clock cycle: drive memory response, compare outputs with the model, advance model.
  task automatic step();
    logic        rv;
    logic [31:0] rdat;
    logic        exp_req;
    logic        fire;
    logic [31:0] faddr;
    int          live;
    req_t        h;
    req_t        nr;
    ent_t        e;
    logic [LW-1:0] exp_fill;
    rv = 1'b0;
    rdat = 32'h0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rdat = pend[0].addr ^ KEY;
    end else if (inject && pend.size() == 0) begin
      rv = 1'b1;
      rdat = 32'hDEAD_BEEF;
    end
    mem_rsp_valid = rv;
    mem_rsp_data  = rdat;
    @(negedge clk);
    live = 0;
    foreach (pend[i]) if (pend[i].ep == ep) live++;
    exp_req = !rst && !redirect_valid && (pend.size() < MAX_OUT) && ((mq.size() + live) < DEPTH);
    exp_fill = LW'(mq.size());
    checks++; if (mem_req_valid !== exp_req) begin errors++; $display("FAIL req_valid cyc %0d got %b want %b", cyc, mem_req_valid, exp_req); end
    checks++; if (mem_req_addr !== m_fetch) begin errors++; $display("FAIL req_addr cyc %0d got %h want %h", cyc, mem_req_addr, m_fetch); end
    checks++; if (inst_valid !== (mq.size() != 0)) begin errors++; $display("FAIL inst_valid cyc %0d got %b want %b", cyc, inst_valid, mq.size() != 0); end
    checks++; if (fill_level !== exp_fill) begin errors++; $display("FAIL fill_level cyc %0d got %0d want %0d", cyc, fill_level, exp_fill); end
    checks++; if (rsp_err !== m_err) begin errors++; $display("FAIL rsp_err cyc %0d got %b want %b", cyc, rsp_err, m_err); end
    if (mq.size() != 0) begin
      checks++; if (inst_pc !== mq[0].pc) begin errors++; $display("FAIL inst_pc cyc %0d got %h want %h", cyc, inst_pc, mq[0].pc); end
      checks++; if (inst_data !== mq[0].dat) begin errors++; $display("FAIL inst_data cyc %0d got %h want %h", cyc, inst_data, mq[0].dat); end
    end
    fire  = mem_req_valid && mem_req_ready;
    faddr = mem_req_addr;
    if (fire) req_log.push_back(faddr);
    if (inst_valid && inst_ready && !redirect_valid && !rst) begin
      obs_log.push_back(inst_pc);
      n_pop++;
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!redirect_valid && mq.size() != 0 && inst_ready) void'(mq.pop_front());
      if (rv) begin
        if (pend.size() == 0) begin
          m_err = 1'b1;
        end else begin
          h = pend.pop_front();
          if (!redirect_valid && h.ep == ep) begin
            e.pc  = m_rsp;
            e.dat = h.addr ^ KEY;
            mq.push_back(e);
            m_rsp = m_rsp + 32'd4;
          end
        end
      end
      if (fire) begin
        nr.addr = faddr;
        nr.ep   = ep;
        nr.due  = cyc + lat;
        pend.push_back(nr);
        m_fetch = m_fetch + 32'd4;
      end
      if (redirect_valid) begin
        ep++;
        mq.delete();
        m_fetch = {redirect_pc[31:2], 2'b00};
        m_rsp   = {redirect_pc[31:2], 2'b00};
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inject = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    inst_ready = 1'b0;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    @(posedge clk);
    #1;
    model_reset();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    step();
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc got %h want 0", inst_pc); end
    checks++; if (inst_data !== 32'h0) begin errors++; $display("FAIL rst_inst_data got %h want 0", inst_data); end
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL rst_fill got %0d want 0", fill_level); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", mem_req_valid); end
    checks++; if (mem_req_addr !== RESET_PC) begin errors++; $display("FAIL rst_req_addr got %h want %h", mem_req_addr, RESET_PC); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b want 0", rsp_err); end
    rst = 1'b0;
    #1;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("FAIL first_req_valid got %b want 1", mem_req_valid); end
  endtask

  task automatic test_stream();
    int n0;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    obs_log.delete();
    repeat (10) step();
    n0 = n_pop;
    repeat (20) step();
    checks++; if (n_pop - n0 != 20) begin errors++; $display("FAIL stream_rate got %0d want 20", n_pop - n0); end
    checks++;
    if (obs_log.size() < 3 || obs_log[0] !== 32'h0 || obs_log[1] !== 32'h4 || obs_log[2] !== 32'h8) begin
      errors++; $display("FAIL stream_order got %0d pops first %h", obs_log.size(), (obs_log.size() != 0) ? obs_log[0] : 32'hx);
    end
  endtask

  task automatic test_fill();
    do_reset();
    lat = 1;
    inst_ready = 1'b0;
    req_log.delete();
    repeat (10) step();
    checks++; if (req_log.size() != 4) begin errors++; $display("FAIL fill_nreq got %0d want 4", req_log.size()); end
    checks++; if (req_log.size() < 4 || req_log[3] !== 32'hC) begin errors++; $display("FAIL fill_last_addr got %h want c", (req_log.size() != 0) ? req_log[req_log.size()-1] : 32'hx); end
    checks++; if (fill_level !== LW'(4)) begin errors++; $display("FAIL fill_level_full got %0d want 4", fill_level); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL fill_req_stall got %b want 0", mem_req_valid); end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    repeat (6) step();
    checks++; if (req_log.size() != 5) begin errors++; $display("FAIL refill_nreq got %0d want 5", req_log.size()); end
    checks++; if (req_log.size() < 5 || req_log[4] !== 32'h10) begin errors++; $display("FAIL refill_addr got %h want 10", (req_log.size() != 0) ? req_log[req_log.size()-1] : 32'hx); end
  endtask

  task automatic test_redirect();
    int k;
    int stale;
    do_reset();
    lat = 3;
    inst_ready = 1'b1;
    k = 0;
    while (pend.size() != 3 && k < 20) begin step(); k++; end
    checks++; if (pend.size() != 3) begin errors++; $display("FAIL redir_setup timeout got %0d in flight want 3", pend.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    req_log.delete();
    obs_log.delete();
    step();
    redirect_valid = 1'b0;
    repeat (25) step();
    checks++; if (req_log.size() == 0 || req_log[0] !== 32'h100) begin errors++; $display("FAIL redir_first_req got %h want 100", (req_log.size() != 0) ? req_log[0] : 32'hx); end
    checks++; if (obs_log.size() < 2 || obs_log[0] !== 32'h100 || obs_log[1] !== 32'h104) begin errors++; $display("FAIL redir_first_inst got %h want 100", (obs_log.size() != 0) ? obs_log[0] : 32'hx); end
    stale = 0;
    foreach (obs_log[i]) if (obs_log[i] < 32'h100) stale++;
    checks++; if (stale != 0) begin errors++; $display("FAIL redir_stale got %0d stale want 0", stale); end
  endtask

  task automatic test_redirect_collide();
    int k;
    do_reset();
    lat = 1;
    inst_ready = 1'b1;
    k = 0;
    while (!(mq.size() != 0 && pend.size() != 0 && pend[0].due <= cyc) && k < 30) begin step(); k++; end
    checks++; if (k >= 30) begin errors++; $display("FAIL collide_setup timeout got %0d cycles want <30", k); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    obs_log.delete();
    step();
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL collide_fill got %0d want 0", fill_level); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL collide_inst_valid got %b want 0", inst_valid); end
    redirect_valid = 1'b0;
    repeat (10) step();
    checks++; if (obs_log.size() == 0 || obs_log[0] !== 32'h200) begin errors++; $display("FAIL collide_first_inst got %h want 200", (obs_log.size() != 0) ? obs_log[0] : 32'hx); end
  endtask

  task automatic test_unexpected_wrap();
    int k;
    do_reset();
    lat = 1;
    inst_ready = 1'b0;
    k = 0;
    while (!(pend.size() == 0 && mq.size() == DEPTH) && k < 30) begin step(); k++; end
    checks++; if (k >= 30) begin errors++; $display("FAIL unexp_setup timeout got %0d cycles want <30", k); end
    inject = 1'b1;
    step();
    inject = 1'b0;
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL unexp_err got %b want 1", rsp_err); end
    checks++; if (fill_level !== LW'(DEPTH)) begin errors++; $display("FAIL unexp_fill got %0d want %0d", fill_level, DEPTH); end
    repeat (5) step();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL unexp_sticky got %b want 1", rsp_err); end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    inst_ready = 1'b1;
    req_log.delete();
    obs_log.delete();
    step();
    redirect_valid = 1'b0;
    repeat (10) step();
    checks++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_req got %h want 0 after fffffffc", (req_log.size() > 1) ? req_log[1] : 32'hx); end
    checks++; if (obs_log.size() < 3 || obs_log[0] !== 32'hFFFF_FFFC || obs_log[1] !== 32'h0 || obs_log[2] !== 32'h4) begin errors++; $display("FAIL wrap_inst got %h want 0 after fffffffc", (obs_log.size() > 1) ? obs_log[1] : 32'hx); end
  endtask

  task automatic test_reset_mid();
    int k;
    lat = 2;
    inst_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    k = 0;
    while (!(pend.size() >= 2 && mq.size() >= 2) && k < 30) begin step(); k++; end
    checks++; if (k >= 30) begin errors++; $display("FAIL rstmid_setup timeout got %0d cycles want <30", k); end
    rst = 1'b1;
    step();
    checks++; if (fill_level !== '0) begin errors++; $display("FAIL rstmid_fill got %0d want 0", fill_level); end
    checks++; if (inst_valid !== 1'b0 || inst_pc !== 32'h0 || inst_data !== 32'h0) begin errors++; $display("FAIL rstmid_inst got %b/%h/%h want 0/0/0", inst_valid, inst_pc, inst_data); end
    checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_req got %b/%h want 0/%h", mem_req_valid, mem_req_addr, RESET_PC); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", rsp_err); end
    rst = 1'b0;
    req_log.delete();
    repeat (5) step();
    checks++; if (req_log.size() == 0 || req_log[0] !== RESET_PC) begin errors++; $display("FAIL rstmid_restart got %h want %h", (req_log.size() != 0) ? req_log[0] : 32'hx, RESET_PC); end
  endtask

  task automatic test_random();
    int n0;
    do_reset();
    n0 = n_pop;
    repeat (600) begin
      mem_req_ready  = ($urandom % 4) != 0;
      inst_ready     = ($urandom % 3) != 0;
      lat            = int'($urandom_range(1, 4));
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc    = $urandom;
      inject         = (pend.size() == 0) && (($urandom % 60) == 0);
      step();
    end
    inject = 1'b0;
    redirect_valid = 1'b0;
    checks++; if (n_pop - n0 < 100) begin errors++; $display("FAIL random_progress got %0d pops want >=100", n_pop - n0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_redirect_collide();
    test_unexpected_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
